onchip_mem_bist: RTL and testbench
==================================

Name: onchip_mem_bist

Overview:
- Avalon-MM-style master that sits directly upstream of the 32-bit, 32000-word single-port on-chip RAM and drives its address, byteenable, chipselect, write, writedata and clken inputs.
- On a start pulse it writes an address-derived pattern over a word range, then reads the range back.
- Each readback word is compared against the expected pattern, using the RAM's fixed 1-cycle read latency.
- It reports pass/fail, error count and first failing address, for board bring-up and unit tests of the memory path.

Parameters:
- ADDR_W, 15, word address width of the RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 32000, number of words; all addresses wrap modulo DEPTH.
- CNT_W, 16, width of word_count and err_count.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running test.
- base_addr  in  ADDR_W  first word address; must be < DEPTH.
- word_count  in  CNT_W  number of words to test; values > DEPTH are clamped to DEPTH.
- seed  in  DATA_W  pattern seed.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test completion.
- pass  out  1  result of the last completed test; held until the next start.
- err_count  out  CNT_W  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  always all-ones while busy.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; high while busy.
- mem_readdata  in  DATA_W  RAM read data; valid 1 cycle after the read address is presented.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Index, counters and capture registers cleared.
- Pattern:
  - pat(a) = seed + zero-extended a, modulo 2^DATA_W.
  - Address for index i = (base_addr + i) mod DEPTH. Wrap from DEPTH-1 to 0 is computed without a divider, by compare-and-subtract.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - start=1 with N = clamp(word_count) > 0 → WRITE; clear err_count and first_err_addr; set pass=0.
  - start=1 with N = 0 → DONE directly, with no memory access and a final pass=1.
- WRITE:
  - Each cycle: chipselect=1, write=1, address/writedata = addr(i)/pat(addr(i)); i increments.
  - After the N-th write: i=0 → READ.
- READ:
  - Each cycle: chipselect=1, write=0, address = addr(i).
  - The expected value and address are registered into a 1-deep pipeline with a valid bit.
  - After the N-th read → DRAIN.
- Compare: in every cycle where the pipeline is valid, mem_readdata is compared with the registered expected value.
  - On mismatch, err_count increments (saturating).
  - first_err_addr is loaded only on the first mismatch, i.e. when err_count == 0 before the increment.
- DRAIN:
  - chipselect=0.
  - The final pipelined compare executes → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - pass = (final err_count == 0).
  - → IDLE.
- busy: 1 in WRITE, READ and DRAIN; 0 otherwise.
- Timing: with start sampled at edge k and N > 0:
  - writes occur in cycles k+1 .. k+N;
  - reads occur in cycles k+N+1 .. k+2N;
  - done occurs in cycle k+2N+2.
- start while busy is ignored.
- abort=1 in WRITE, READ or DRAIN:
  - next state IDLE, with no done pulse.
  - pass=0, pending compare discarded, chipselect=0 next cycle.
  - abort has priority over start in the same cycle.
- reset_n low mid-test:
  - immediate return to IDLE with all outputs 0.
  - RAM contents are not restored.
- mem_write never asserts outside WRITE; mem_chipselect never asserts in IDLE or DONE.

Optional Feature:
- Macro: ONCHIP_MEM_BIST_INV_PASS_EN.
- Defined:
  - After DRAIN, a second write/read/drain sequence runs with pattern ~pat(a). This adds states WRITE_INV, READ_INV and DRAIN_INV.
  - err_count and first_err_addr accumulate across both passes.
  - done occurs in cycle k+4N+3.
- Undefined: single pass only; no inverted-pattern logic is synthesised.

Test Plan:
- Base/count test: base_addr=0x0010, word_count=4, seed=0x1000_0000, clean RAM model.
  - Writes 0x1000_0010..0x1000_0013 at addresses 0x10..0x13.
  - done at k+10, pass=1, err_count=0.
- Wrap test: base_addr=31998, word_count=4.
  - Addresses run 31998, 31999, 0, 1 in both the write and read phases.
  - pass=1.
- Fault injection: RAM model forces bit 5 stuck-at-1 on address 0x0102; base 0x0100, count 8, seed 0.
  - err_count=1, first_err_addr=0x0102, pass=0.
- Zero and clamp test: word_count=0 → done at k+2 with no chipselect ever asserted, pass=1. word_count=40000 → exactly 32000 writes and 32000 reads.
- Abort test: abort during READ at index 3 of 8.
  - chipselect drops next cycle; no done pulse; busy=0; pass=0.
  - A subsequent start is accepted normally.
- Reset test: assert reset_n low mid-WRITE.
  - All outputs 0 asynchronously.
  - After release, start runs a full test with pass=1.

Source files
------------

// File: rtl/onchip_mem_bist_if.sv
// Avalon-MM style bus between the BIST master and the on-chip RAM.
// The master drives the command side; the RAM returns read data one cycle later.
interface onchip_mem_bist_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;

    modport master (
        output mem_address, mem_byteenable, mem_chipselect,
        output mem_write, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport slave (
        input  mem_address, mem_byteenable, mem_chipselect,
        input  mem_write, mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/onchip_mem_bist.sv
// Write/readback BIST master for the single-port on-chip RAM.
// ONCHIP_MEM_BIST_INV_PASS_EN adds a second pass with the inverted pattern.
module onchip_mem_bist #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32000,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    onchip_mem_bist_if.master mem
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
`ifdef ONCHIP_MEM_BIST_INV_PASS_EN
        , S_WRITE_INV, S_READ_INV, S_DRAIN_INV
`endif
    } state_t;

    state_t            st_q;
    logic [CNT_W-1:0]  idx_q, n_q, err_q;
    logic [ADDR_W-1:0] base_q, nxt_q, addr_q, ea_q, fea_q;
    logic [DATA_W-1:0] seed_q, pat_q, exp_q;
    logic [BE_W-1:0]   be_q;
    logic              cs_q, we_q, clken_q, busy_q, done_q, pass_q, pv_q;

    logic [CNT_W-1:0]  n_clamp, err_d;
    logic              st_idle, st_done, in_wr, in_rd, in_dr, ph_inv;
    logic              act_abort, mismatch, last;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + (ADDR_W+1)'(1);
        if (s >= (ADDR_W+1)'(DEPTH))
            s = s - (ADDR_W+1)'(DEPTH);
        return s[ADDR_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] pat(
        input logic [DATA_W-1:0] sd,
        input logic [ADDR_W-1:0] a,
        input logic              inv
    );
        logic [DATA_W-1:0] p;
        p = sd + DATA_W'(a);
        return inv ? ~p : p;
    endfunction

    always_comb begin
        n_clamp = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
        st_idle = (st_q == S_IDLE);
        st_done = (st_q == S_DONE);
        in_wr   = (st_q == S_WRITE);
        in_rd   = (st_q == S_READ);
        in_dr   = (st_q == S_DRAIN);
        ph_inv  = 1'b0;
`ifdef ONCHIP_MEM_BIST_INV_PASS_EN
        in_wr   = in_wr | (st_q == S_WRITE_INV);
        in_rd   = in_rd | (st_q == S_READ_INV);
        in_dr   = in_dr | (st_q == S_DRAIN_INV);
        ph_inv  = (st_q == S_WRITE_INV) | (st_q == S_READ_INV);
`endif
        act_abort = abort & (in_wr | in_rd | in_dr);
        mismatch  = pv_q & (mem.mem_readdata != exp_q) & ~act_abort;
        err_d     = (mismatch && err_q != '1) ? err_q + CNT_W'(1) : err_q;
        last      = (idx_q == n_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            err_q   <= '0;
            base_q  <= '0;
            nxt_q   <= '0;
            addr_q  <= '0;
            ea_q    <= '0;
            fea_q   <= '0;
            seed_q  <= '0;
            pat_q   <= '0;
            exp_q   <= '0;
            be_q    <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            clken_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Read data arrives one cycle after the address; keep expectation alongside.
            pv_q   <= in_rd;
            if (in_rd) begin
                exp_q <= pat_q;
                ea_q  <= addr_q;
            end
            if (mismatch) begin
                err_q <= err_d;
                if (err_q == '0)
                    fea_q <= ea_q;
            end

            unique case (1'b1)
                st_idle: begin
                    if (start) begin
                        base_q <= base_addr;
                        seed_q <= seed;
                        n_q    <= n_clamp;
                        err_q  <= '0;
                        fea_q  <= '0;
                        pass_q <= 1'b0;
                        if (n_clamp != '0) begin
                            st_q    <= S_WRITE;
                            busy_q  <= 1'b1;
                            clken_q <= 1'b1;
                            be_q    <= '1;
                            cs_q    <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= base_addr;
                            pat_q   <= pat(seed, base_addr, 1'b0);
                            nxt_q   <= wrap_inc(base_addr);
                            idx_q   <= CNT_W'(1);
                        end else begin
                            st_q <= S_DONE;
                        end
                    end
                end
                in_wr, in_rd: begin
                    if (!last) begin
                        addr_q <= nxt_q;
                        pat_q  <= pat(seed_q, nxt_q, ph_inv);
                        nxt_q  <= wrap_inc(nxt_q);
                        idx_q  <= idx_q + CNT_W'(1);
                    end else if (in_wr) begin
`ifdef ONCHIP_MEM_BIST_INV_PASS_EN
                        st_q <= ph_inv ? S_READ_INV : S_READ;
`else
                        st_q <= S_READ;
`endif
                        we_q   <= 1'b0;
                        addr_q <= base_q;
                        pat_q  <= pat(seed_q, base_q, ph_inv);
                        nxt_q  <= wrap_inc(base_q);
                        idx_q  <= CNT_W'(1);
                    end else begin
`ifdef ONCHIP_MEM_BIST_INV_PASS_EN
                        st_q <= ph_inv ? S_DRAIN_INV : S_DRAIN;
`else
                        st_q <= S_DRAIN;
`endif
                        cs_q   <= 1'b0;
                        addr_q <= '0;
                        pat_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                in_dr: begin
`ifdef ONCHIP_MEM_BIST_INV_PASS_EN
                    if (st_q == S_DRAIN) begin
                        st_q   <= S_WRITE_INV;
                        cs_q   <= 1'b1;
                        we_q   <= 1'b1;
                        addr_q <= base_q;
                        pat_q  <= pat(seed_q, base_q, 1'b1);
                        nxt_q  <= wrap_inc(base_q);
                        idx_q  <= CNT_W'(1);
                    end else begin
`endif
                        st_q    <= S_DONE;
                        busy_q  <= 1'b0;
                        clken_q <= 1'b0;
                        be_q    <= '0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
`ifdef ONCHIP_MEM_BIST_INV_PASS_EN
                    end
`endif
                end
                st_done: begin
                    // Zero-length tests reach DONE without done set yet.
                    if (done_q) begin
                        st_q <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0);
                    end
                end
                default: st_q <= S_IDLE;
            endcase

            if (act_abort) begin
                st_q    <= S_IDLE;
                busy_q  <= 1'b0;
                clken_q <= 1'b0;
                be_q    <= '0;
                cs_q    <= 1'b0;
                we_q    <= 1'b0;
                addr_q  <= '0;
                pat_q   <= '0;
                idx_q   <= '0;
                pv_q    <= 1'b0;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
            end
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign err_count          = err_q;
    assign first_err_addr     = fea_q;
    assign mem.mem_address    = addr_q;
    assign mem.mem_byteenable = be_q;
    assign mem.mem_chipselect = cs_q;
    assign mem.mem_write      = we_q;
    assign mem.mem_writedata  = pat_q;
    assign mem.mem_clken      = clken_q;

endmodule

// File: tb/tb_onchip_mem_bist.sv
// Randomized bench for onchip_mem_bist with a RAM model and a list-based
// reference of the expected write/read traffic and result.
module tb_onchip_mem_bist;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int DEPTH = 32000;
    localparam int CW    = 16;

    typedef struct {
        int          a;
        logic [31:0] d;
        int          lbl;
    } ev_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_count;
    logic [AW-1:0] first_err_addr;

    onchip_mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    onchip_mem_bist #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .word_count(word_count),
        .seed(seed),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_addr(first_err_addr),
        .mem(mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    // RAM model: 1-cycle registered read, optional stuck-at-1 bits on one word.
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] rdata;
    bit          fault_en;
    int          fault_addr;
    logic [31:0] fault_mask;

    assign mif.mem_readdata = rdata;

    always @(posedge clk) begin
        if (mif.mem_clken && mif.mem_chipselect) begin
            if (mif.mem_write)
                ram[mif.mem_address] <= mif.mem_writedata;
            else if (fault_en && int'(mif.mem_address) == fault_addr)
                rdata <= ram[mif.mem_address] | fault_mask;
            else
                rdata <= ram[mif.mem_address];
        end
    end

    ev_t wq[$];
    ev_t rq[$];
    int  done_cnt;
    int  done_lbl;
    int  viol;

    always @(negedge clk) begin
        if (reset_n) begin
            if (mif.mem_chipselect && mif.mem_write)
                wq.push_back('{int'(mif.mem_address), mif.mem_writedata, cnt + 1});
            if (mif.mem_chipselect && !mif.mem_write)
                rq.push_back('{int'(mif.mem_address), 32'h0, cnt + 1});
            if (done) begin
                done_cnt = done_cnt + 1;
                done_lbl = cnt + 1;
            end
            if (busy && (mif.mem_byteenable != '1 || !mif.mem_clken))
                viol = viol + 1;
            if (!busy && (mif.mem_chipselect || mif.mem_write || mif.mem_clken))
                viol = viol + 1;
            if (mif.mem_write && !mif.mem_chipselect)
                viol = viol + 1;
            if (done && busy)
                viol = viol + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_test(
        input string       nm,
        input int          b,
        input int          wc,
        input logic [31:0] sd,
        input bit          fe,
        input int          fa,
        input logic [31:0] fm
    );
        int          n, k, nph, dexp, errs, fea_e, bad_w, bad_r, ph, i, a;
        logic [31:0] p;
        n = (wc > DEPTH) ? DEPTH : wc;
`ifdef ONCHIP_MEM_BIST_INV_PASS_EN
        nph  = 2;
        dexp = (n == 0) ? 2 : 4 * n + 3;
`else
        nph  = 1;
        dexp = 2 * n + 2;
`endif
        fault_en   = fe;
        fault_addr = fa;
        fault_mask = fm;
        @(negedge clk);
        wq.delete();
        rq.delete();
        done_cnt   = 0;
        done_lbl   = 0;
        viol       = 0;
        base_addr  = AW'(b);
        word_count = CW'(wc);
        seed       = sd;
        start      = 1'b1;
        k          = cnt + 1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4 * n + 64 && done_cnt == 0; c++)
            @(posedge clk);
        repeat (3) @(negedge clk);

        errs  = 0;
        fea_e = 0;
        for (ph = 0; ph < nph; ph++) begin
            for (i = 0; i < n; i++) begin
                a = (b + i) % DEPTH;
                p = sd + a;
                if (ph != 0) p = ~p;
                if (fe && a == fa && (p | fm) != p) begin
                    if (errs == 0) fea_e = a;
                    errs++;
                end
            end
        end

        bad_w = 0;
        bad_r = 0;
        if (n == 0) begin
            bad_w = wq.size();
            bad_r = rq.size();
        end else begin
            foreach (wq[j]) begin
                ph = j / n;
                i  = j % n;
                a  = (b + i) % DEPTH;
                p  = sd + a;
                if (ph != 0) p = ~p;
                if (wq[j].a != a || wq[j].d != p || wq[j].lbl != k + 1 + i + ph * (2 * n + 1))
                    bad_w++;
            end
            foreach (rq[j]) begin
                ph = j / n;
                i  = j % n;
                a  = (b + i) % DEPTH;
                if (rq[j].a != a || rq[j].lbl != k + n + 1 + i + ph * (2 * n + 1))
                    bad_r++;
            end
        end

        chk({nm, ".ndone"}, 64'(done_cnt), 64'(1));
        chk({nm, ".dcyc"}, 64'(done_lbl - k), 64'(dexp));
        chk({nm, ".nwr"}, 64'(wq.size()), 64'(n * nph));
        chk({nm, ".nrd"}, 64'(rq.size()), 64'(n * nph));
        chk({nm, ".wseq"}, 64'(bad_w), 64'(0));
        chk({nm, ".rseq"}, 64'(bad_r), 64'(0));
        chk({nm, ".pass"}, 64'(pass), 64'(errs == 0));
        chk({nm, ".err"}, 64'(err_count), 64'(errs > 65535 ? 65535 : errs));
        chk({nm, ".fea"}, 64'(first_err_addr), 64'(fea_e));
        chk({nm, ".busy"}, 64'(busy), 64'(0));
        chk({nm, ".viol"}, 64'(viol), 64'(0));
    endtask

    int          k0;
    int          rb, rw, rfa;
    bit          rfe;
    logic [31:0] rsd, rfm;

    initial begin
        reset_n    = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        seed       = '0;
        fault_en   = 1'b0;
        fault_addr = 0;
        fault_mask = '0;
        rdata      = '0;
        done_cnt   = 0;
        done_lbl   = 0;
        viol       = 0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.pass", 64'(pass), 64'(0));
        chk("rst.bus", 64'(|{mif.mem_chipselect, mif.mem_write, mif.mem_clken,
                              mif.mem_byteenable, mif.mem_address, mif.mem_writedata,
                              done, err_count, first_err_addr}), 64'(0));
        reset_n = 1'b1;

        run_test("base", 16'h10, 4, 32'h1000_0000, 1'b0, 0, 32'h0);
        chk("base.wd0", 64'(wq[0].d), 64'h1000_0010);
        chk("base.wd3", 64'(wq[3].d), 64'h1000_0013);
        chk("base.wa3", 64'(wq[3].a), 64'h13);

        run_test("wrap", 31998, 4, $urandom, 1'b0, 0, 32'h0);
        chk("wrap.wa1", 64'(wq[1].a), 64'(31999));
        chk("wrap.wa2", 64'(wq[2].a), 64'(0));
        chk("wrap.ra3", 64'(rq[3].a), 64'(1));

        run_test("fault", 16'h100, 8, 32'h0, 1'b1, 16'h102, 32'h20);
        chk("fault.err", 64'(err_count), 64'(1));
        chk("fault.fea", 64'(first_err_addr), 64'h102);
        chk("fault.pass", 64'(pass), 64'(0));

        run_test("zero", 16'h55, 0, $urandom, 1'b0, 0, 32'h0);
        chk("zero.pass", 64'(pass), 64'(1));

        run_test("clamp", int'($urandom_range(0, DEPTH - 1)), 40000, $urandom, 1'b0, 0, 32'h0);

        // Abort while the fourth of eight reads is on the bus.
        @(negedge clk);
        base_addr  = AW'(16'h200);
        word_count = CW'(8);
        seed       = $urandom;
        fault_en   = 1'b0;
        start      = 1'b1;
        k0         = cnt + 1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40 && cnt < k0 + 11; c++)
            @(negedge clk);
        chk("abort.ra3", 64'(mif.mem_address), 64'h203);
        chk("abort.rd", 64'({mif.mem_chipselect, mif.mem_write}), 64'b10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.cs", 64'(mif.mem_chipselect), 64'(0));
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.pass", 64'(pass), 64'(0));
        repeat (30) @(negedge clk);
        chk("abort.nodone", 64'(done_cnt), 64'(0));
        run_test("postabort", 16'h200, 8, $urandom, 1'b0, 0, 32'h0);

        // Asynchronous reset in the middle of the write phase.
        @(negedge clk);
        base_addr  = AW'(16'h300);
        word_count = CW'(20);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid.busy", 64'(busy), 64'(0));
        chk("rstmid.cs", 64'(mif.mem_chipselect), 64'(0));
        chk("rstmid.all", 64'(|{mif.mem_write, mif.mem_clken, mif.mem_byteenable,
                                 mif.mem_address, mif.mem_writedata, done, pass,
                                 err_count, first_err_addr}), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_test("postrst", 16'h300, 20, $urandom, 1'b0, 0, 32'h0);

        for (int t = 0; t < 12; t++) begin
            rb = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 2) == 0)
                rb = DEPTH - 1 - $urandom_range(0, 10);
            rw  = $urandom_range(0, 40);
            rsd = $urandom;
            rfe = ($urandom_range(0, 1) == 1);
            rfa = (rb + $urandom_range(0, rw)) % DEPTH;
            rfm = 32'h1 << $urandom_range(0, 31);
            run_test($sformatf("rnd%0d", t), rb, rw, rsd, rfe, rfa, rfm);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
